muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit for the EX stage. It replaces the fixed-latency multiply stall path.
- Supports signed and unsigned multiply and divide on WIDTH-bit operands, with configurable multiply throughput.
- Uses a start/done handshake and drives a stall output that freezes the pipe registers.
- Supports a synchronous flush to abort on branch/jump squash.

Parameters:
- WIDTH, 32: operand and result width. Must be even and >= 4.
- MUL_STEP, 1: multiplier bits retired per cycle. Legal values are 1, 2, 4. Must divide WIDTH. Division always retires 1 bit per cycle.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request a new operation; sampled only in IDLE or DONE.
- op  in  2  operation select: 00 unsigned mul, 01 signed mul, 10 unsigned div, 11 signed div.
- flush  in  1  synchronous abort of any in-flight operation.
- operand_a  in  WIDTH  multiplicand or dividend.
- operand_b  in  WIDTH  multiplier or divisor.
- stall  out  1  combinational; holds the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- busy  out  1  registered; high in CALC or FIX.
- done  out  1  registered; one-cycle completion pulse.
- result_lo  out  WIDTH  product low half, or quotient.
- result_hi  out  WIDTH  product high half, or remainder.
- div_by_zero  out  1  set with done when a divide has operand_b == 0.

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE.
  - busy, done, div_by_zero, result_lo, result_hi = 0.
  - Internal accumulator, counter and sign flags cleared.
  - Reset takes effect immediately, including mid-operation; no done follows.
- States: IDLE, CALC, FIX, DONE.
- Accept: at a posedge with state in {IDLE, DONE}, start=1 and flush=0:
  - latch op;
  - latch |operand_a| and |operand_b| (magnitudes only for the signed ops);
  - latch result sign flags; clear count;
  - go to CALC.
- Divide by zero: if op is a divide and operand_b == 0 at accept, go straight to FIX.
- Start in CALC or FIX is ignored; no queueing.
- CALC, multiply:
  - shift-add on a 2*WIDTH accumulator, MUL_STEP bits per cycle;
  - WIDTH/MUL_STEP cycles, then go to FIX.
- CALC, divide:
  - restoring division, 1 quotient bit per cycle;
  - WIDTH cycles, then go to FIX.
- FIX: apply sign correction, register both result words, set done=1, go to DONE.
  - Signed mul: negate the full 2*WIDTH product if sign(a) XOR sign(b).
  - Signed div: quotient negated if sign(a) XOR sign(b); remainder takes the sign of the dividend.
  - Div by zero: result_lo = all ones; result_hi = operand_a (unmodified); div_by_zero = 1.
  - Most-negative / -1: quotient = most-negative (wraps), remainder = 0, no flag.
- DONE:
  - done=1 for exactly this cycle;
  - next state is IDLE, or CALC/FIX if start is accepted (back-to-back issue allowed).
- Latency from the accepting edge to the edge after which done=1:
  - multiply: WIDTH/MUL_STEP + 1 cycles (default 33);
  - divide: WIDTH + 1 cycles;
  - divide by zero: 1 cycle.
- stall = (start & state in {IDLE, DONE} & ~flush) | state==CALC | state==FIX.
  - stall is low in DONE, so the pipe advances and captures the results that cycle.
- Results and div_by_zero hold their value until the next FIX. div_by_zero clears on the next accept.
- Flush:
  - flush=1 at a posedge forces IDLE; busy=0 and done=0 next cycle.
  - result_lo, result_hi and div_by_zero are left unchanged.
  - Flush wins over a simultaneous start.
- The unit performs all arithmetic modulo 2^WIDTH per half and never raises overflow signals.

Test Plan:
- Unsigned mul, WIDTH=32, MUL_STEP=1: start with a=0xFFFFFFFF, b=0xFFFFFFFF, op=00 -> stall high for 34 cycles counting the start cycle; done 33 edges after accept; result_hi=0xFFFFFFFE, result_lo=0x00000001.
- Signed ops:
  - op=01, a=-3, b=7 -> result_hi=0xFFFFFFFF, result_lo=0xFFFFFFEB.
  - op=11, a=-7, b=2 -> result_lo=0xFFFFFFFD, result_hi=0xFFFFFFFF.
  - op=11, a=0x80000000, b=0xFFFFFFFF -> result_lo=0x80000000, result_hi=0, div_by_zero=0.
- Divide by zero: op=10, a=5, b=0 -> done on the edge after accept; result_lo=0xFFFFFFFF, result_hi=5, div_by_zero=1. A following valid divide clears the flag.
- Flush and start interactions:
  - Flush 10 cycles into a multiply -> busy=0 next cycle; no done pulse; results equal the previous operation's values.
  - A new start then completes normally.
  - Start+flush in the same IDLE cycle -> stays IDLE.
- Reset and throughput:
  - Drive reset low mid-CALC -> all outputs 0 without waiting for a clock edge.
  - Rebuild with MUL_STEP=4: 0x12345678 * 0x9ABCDEF0 unsigned -> done 9 edges after accept; product 0x0B00EA4E_242D2080.
- Back-to-back: start held high on the DONE cycle -> the second operation is accepted with no idle gap, and the first result is visible while done=1.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit for the EX stage: shift-add multiply (MUL_STEP bits/cycle),
// restoring divide (1 bit/cycle), start/done handshake with pipeline stall and flush abort.
module muldiv_unit #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MUL_STEP = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             flush,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned PW = WIDTH + MUL_STEP;
  localparam int unsigned AW = 2 * WIDTH;
  localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH / MUL_STEP - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t          state, next_state;
  logic [1:0]      op_r;
  logic [WIDTH-1:0] b_mag;
  logic [AW-1:0]   acc;
  logic [CW-1:0]   count;
  logic            neg_q, neg_r, dbz_r;

  logic             accept_c, in_dbz_c, a_neg_c, b_neg_c, last_c;
  logic [WIDTH-1:0] a_mag_c, b_mag_c;
  logic [MUL_STEP-1:0] digit_c;
  logic [PW-1:0]    pp_c, sum_c;
  logic [WIDTH:0]   rem_sh_c, diff_c;
  logic [AW-1:0]    step_c, prod_c;
  logic [WIDTH-1:0] fix_lo_c, fix_hi_c;

  // Operand capture: magnitudes for signed ops, divide-by-zero detection
  always_comb begin
    accept_c = start & ~flush & ((state == S_IDLE) | (state == S_DONE));
    in_dbz_c = op[1] & (operand_b == '0);
    a_neg_c  = op[0] & operand_a[WIDTH-1];
    b_neg_c  = op[0] & operand_b[WIDTH-1];
    a_mag_c  = a_neg_c ? (~operand_a + WIDTH'(1)) : operand_a;
    b_mag_c  = b_neg_c ? (~operand_b + WIDTH'(1)) : operand_b;
    last_c   = (count == (op_r[1] ? DIV_LAST : MUL_LAST));
    stall    = accept_c | (state == S_CALC) | (state == S_FIX);
  end

  // One iteration: shift-add multiply step or restoring divide step on acc = {hi, lo}
  always_comb begin
    digit_c  = acc[MUL_STEP-1:0];
    pp_c     = PW'(b_mag) * PW'(digit_c);
    sum_c    = PW'(acc[AW-1:WIDTH]) + pp_c;
    rem_sh_c = {acc[AW-1:WIDTH], acc[WIDTH-1]};
    diff_c   = rem_sh_c - {1'b0, b_mag};
    step_c   = acc;
    if (op_r[1]) begin
      if (!diff_c[WIDTH]) step_c = {diff_c[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else                step_c = {rem_sh_c[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      step_c = AW'({sum_c, acc[WIDTH-1:0]} >> MUL_STEP);
    end
  end

  // Sign correction applied in FIX
  always_comb begin
    prod_c   = neg_q ? (~acc + AW'(1)) : acc;
    fix_lo_c = prod_c[WIDTH-1:0];
    fix_hi_c = prod_c[AW-1:WIDTH];
    if (dbz_r) begin
      fix_lo_c = '1;
      fix_hi_c = acc[WIDTH-1:0];
    end else if (op_r[1]) begin
      fix_lo_c = neg_q ? (~acc[WIDTH-1:0] + WIDTH'(1)) : acc[WIDTH-1:0];
      fix_hi_c = neg_r ? (~acc[AW-1:WIDTH] + WIDTH'(1)) : acc[AW-1:WIDTH];
    end
  end

  // Next-state logic; flush overrides everything
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE: if (accept_c) next_state = in_dbz_c ? S_FIX : S_CALC;
      S_CALC: if (last_c) next_state = S_FIX;
      S_FIX:  next_state = S_DONE;
      S_DONE: next_state = accept_c ? (in_dbz_c ? S_FIX : S_CALC) : S_IDLE;
      default: next_state = S_IDLE;
    endcase
    if (flush) next_state = S_IDLE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state == S_CALC) | (next_state == S_FIX);
      done  <= (next_state == S_DONE);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_r        <= '0;
      b_mag       <= '0;
      acc         <= '0;
      count       <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dbz_r       <= 1'b0;
      result_lo   <= '0;
      result_hi   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (accept_c) begin
        op_r        <= op;
        b_mag       <= b_mag_c;
        // divide-by-zero keeps the raw dividend for result_hi
        acc         <= {{WIDTH{1'b0}}, in_dbz_c ? operand_a : a_mag_c};
        count       <= '0;
        neg_q       <= a_neg_c ^ b_neg_c;
        neg_r       <= op[1] & a_neg_c;
        dbz_r       <= in_dbz_c;
        div_by_zero <= 1'b0;
      end else if (state == S_CALC) begin
        acc   <= step_c;
        count <= count + CW'(1);
      end
      if (state == S_FIX && !flush) begin
        result_lo   <= fix_lo_c;
        result_hi   <= fix_hi_c;
        div_by_zero <= dbz_r;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases, random ops against an arithmetic
// reference model, flush/reset/back-to-back behaviour, and a MUL_STEP=4 instance.
module tb_muldiv_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start, flush;
  logic [1:0]  op;
  logic [31:0] operand_a, operand_b;
  logic        stall, busy, done, div_by_zero;
  logic [31:0] result_lo, result_hi;

  logic        start4, flush4;
  logic [1:0]  op4;
  logic [31:0] a4, b4;
  logic        stall4, busy4, done4, dbz4;
  logic [31:0] lo4, hi4;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  muldiv_unit #(.WIDTH(32), .MUL_STEP(1)) u_dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .flush(flush),
    .operand_a(operand_a), .operand_b(operand_b), .stall(stall), .busy(busy),
    .done(done), .result_lo(result_lo), .result_hi(result_hi), .div_by_zero(div_by_zero)
  );

  muldiv_unit #(.WIDTH(32), .MUL_STEP(4)) u_dut4 (
    .clock(clock), .reset(reset), .start(start4), .op(op4), .flush(flush4),
    .operand_a(a4), .operand_b(b4), .stall(stall4), .busy(busy4),
    .done(done4), .result_lo(lo4), .result_hi(hi4), .div_by_zero(dbz4)
  );

  // Reference: plain 64-bit arithmetic; returns {div_by_zero, hi, lo}
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'd0: p = 64'(a) * 64'(b);
      2'd1: p = 64'(sa * sb);
      2'd2: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        p = {a % b, a / b};
      end
      default: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        p = {32'(sa % sb), 32'(sa / sb)};
      end
    endcase
    return {1'b0, p};
  endfunction

  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] b, input int step);
    if (o[1]) return (b == 32'd0) ? 1 : 33;
    return 32 / step + 1;
  endfunction

  // Issue one op on the selected instance; returns edges from accept to done (capped)
  task automatic issue(input bit sel, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] lo, output logic [31:0] hi, output logic dz);
    @(negedge clock);
    if (sel) begin start4 = 1'b1; op4 = o; a4 = a; b4 = b; end
    else begin start = 1'b1; op = o; operand_a = a; operand_b = b; end
    @(posedge clock); #1;
    start = 1'b0; start4 = 1'b0;
    lat = 0;
    while (((sel ? done4 : done) !== 1'b1) && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
    lo = sel ? lo4 : result_lo;
    hi = sel ? hi4 : result_hi;
    dz = sel ? dbz4 : div_by_zero;
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; flush = 1'b0; op = 2'd0; operand_a = '0; operand_b = '0;
    start4 = 1'b0; flush4 = 1'b0; op4 = 2'd0; a4 = '0; b4 = '0;
    #12;
    tests_run++;
    if ({busy, done, div_by_zero} !== 3'b000) begin
      tests_failed++; $display("FAIL reset_flags got %b want 000", {busy, done, div_by_zero});
    end
    tests_run++;
    if ({result_hi, result_lo} !== 64'd0) begin
      tests_failed++; $display("FAIL reset_results got %h want 0", {result_hi, result_lo});
    end
    @(negedge clock); reset = 1'b1;
    #1;
    tests_run++;
    if (stall !== 1'b0) begin tests_failed++; $display("FAIL reset_stall got %b want 0", stall); end
  endtask

  task automatic test_mul_directed;
    int lat, stall_cnt;
    @(negedge clock);
    start = 1'b1; op = 2'd0; operand_a = 32'hFFFF_FFFF; operand_b = 32'hFFFF_FFFF;
    #1; stall_cnt = (stall === 1'b1) ? 1 : 0;
    @(posedge clock); #1;
    start = 1'b0; lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (stall === 1'b1) stall_cnt++;
      @(posedge clock); #1;
      lat++;
    end
    tests_run++;
    if (lat !== 33) begin tests_failed++; $display("FAIL umul_latency got %0d want 33", lat); end
    tests_run++;
    if (stall_cnt !== 34) begin tests_failed++; $display("FAIL umul_stall_cycles got %0d want 34", stall_cnt); end
    tests_run++;
    if ({result_hi, result_lo} !== 64'hFFFF_FFFE_0000_0001) begin
      tests_failed++; $display("FAIL umul_max got %h want fffffffe00000001", {result_hi, result_lo});
    end
    tests_run++;
    if (stall !== 1'b0) begin tests_failed++; $display("FAIL done_stall got %b want 0", stall); end
  endtask

  task automatic test_signed_and_dbz;
    int lat; logic [31:0] lo, hi; logic dz;
    issue(1'b0, 2'd1, 32'hFFFF_FFFD, 32'd7, lat, lo, hi, dz);
    tests_run++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      tests_failed++; $display("FAIL smul_neg got %h want ffffffffffffffeb", {hi, lo});
    end
    issue(1'b0, 2'd3, 32'hFFFF_FFF9, 32'd2, lat, lo, hi, dz);
    tests_run++;
    if ({hi, lo, lat} !== {64'hFFFF_FFFF_FFFF_FFFD, 32'd33}) begin
      tests_failed++; $display("FAIL sdiv_neg got %h lat %0d want fffffffffffffffd lat 33", {hi, lo}, lat);
    end
    issue(1'b0, 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, lat, lo, hi, dz);
    tests_run++;
    if ({dz, hi, lo} !== {1'b0, 64'h0000_0000_8000_0000}) begin
      tests_failed++; $display("FAIL sdiv_minneg got %b %h want 0 0000000080000000", dz, {hi, lo});
    end
    issue(1'b0, 2'd2, 32'd5, 32'd0, lat, lo, hi, dz);
    tests_run++;
    if ({dz, hi, lo, lat} !== {1'b1, 32'd5, 32'hFFFF_FFFF, 32'd1}) begin
      tests_failed++; $display("FAIL div_by_zero got dz %b %h lat %0d want 1 00000005ffffffff lat 1", dz, {hi, lo}, lat);
    end
    issue(1'b0, 2'd2, 32'd100, 32'd7, lat, lo, hi, dz);
    tests_run++;
    if ({dz, hi, lo} !== {1'b0, 32'd2, 32'd14}) begin
      tests_failed++; $display("FAIL dbz_clear got %b %h want 0 000000020000000e", dz, {hi, lo});
    end
  endtask

  task automatic test_random;
    int lat; logic [31:0] lo, hi, a, b; logic dz; logic [1:0] o; logic [64:0] exp;
    for (int i = 0; i < 50; i++) begin
      bit sel;
      sel = (i >= 40);
      o = 2'($urandom_range(0, 3));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 40)) - 32'd20; b = 32'($urandom_range(0, 10)) - 32'd5; end
        3: b = 32'($urandom_range(1, 300));
        default: ;
      endcase
      exp = model(o, a, b);
      issue(sel, o, a, b, lat, lo, hi, dz);
      tests_run++;
      if ({dz, hi, lo} !== exp || lat !== exp_lat(o, b, sel ? 4 : 1)) begin
        tests_failed++;
        $display("FAIL random[%0d] step%0d op=%0d a=%h b=%h got %b %h lat %0d want %b %h lat %0d",
                 i, sel ? 4 : 1, o, a, b, dz, {hi, lo}, lat, exp[64], exp[63:0], exp_lat(o, b, sel ? 4 : 1));
      end
    end
  endtask

  task automatic test_flush;
    int lat, cyc; logic [31:0] lo, hi; logic dz; bit saw_done;
    issue(1'b0, 2'd0, 32'd3, 32'd5, lat, lo, hi, dz);
    @(negedge clock);
    start = 1'b1; op = 2'd0; operand_a = 32'h1234_5678; operand_b = 32'h0000_FFFF;
    @(posedge clock); #1; start = 1'b0;
    repeat (10) @(posedge clock);
    @(negedge clock); flush = 1'b1;
    @(posedge clock); #1; flush = 1'b0;
    tests_run++;
    if ({busy, done} !== 2'b00) begin tests_failed++; $display("FAIL flush_idle got %b want 00", {busy, done}); end
    saw_done = 1'b0;
    for (cyc = 0; cyc < 40; cyc++) begin
      @(posedge clock); #1;
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    tests_run++;
    if (saw_done !== 1'b0) begin tests_failed++; $display("FAIL flush_no_done got %b want 0", saw_done); end
    tests_run++;
    if ({result_hi, result_lo} !== 64'd15) begin
      tests_failed++; $display("FAIL flush_keep got %h want 000000000000000f", {result_hi, result_lo});
    end
    issue(1'b0, 2'd1, 32'hFFFF_FFFE, 32'hFFFF_FFFE, lat, lo, hi, dz);
    tests_run++;
    if ({hi, lo, lat} !== {64'd4, 32'd33}) begin
      tests_failed++; $display("FAIL after_flush got %h lat %0d want 4 lat 33", {hi, lo}, lat);
    end
    @(negedge clock); @(negedge clock);
    start = 1'b1; flush = 1'b1; op = 2'd0; operand_a = 32'd9; operand_b = 32'd9;
    #1;
    tests_run++;
    if (stall !== 1'b0) begin tests_failed++; $display("FAIL start_flush_stall got %b want 0", stall); end
    @(posedge clock); #1; start = 1'b0; flush = 1'b0;
    saw_done = 1'b0;
    for (cyc = 0; cyc < 5; cyc++) begin
      if (busy === 1'b1 || done === 1'b1) saw_done = 1'b1;
      @(posedge clock); #1;
    end
    tests_run++;
    if (saw_done !== 1'b0 || result_lo !== 32'd4) begin
      tests_failed++; $display("FAIL start_flush_idle got active %b lo %h want 0 lo 4", saw_done, result_lo);
    end
  endtask

  task automatic test_back_to_back;
    int lat; logic [31:0] lo, hi; logic dz;
    issue(1'b0, 2'd0, 32'd1000, 32'd2000, lat, lo, hi, dz);
    tests_run++;
    if ({done, stall, result_lo} !== {2'b10, 32'd2_000_000}) begin
      tests_failed++; $display("FAIL b2b_first got done %b stall %b lo %h want 1 0 001e8480", done, stall, result_lo);
    end
    @(negedge clock);
    start = 1'b1; op = 2'd2; operand_a = 32'd1000; operand_b = 32'd33;
    @(posedge clock); #1; start = 1'b0;
    tests_run++;
    if ({busy, done} !== 2'b10) begin tests_failed++; $display("FAIL b2b_accept got %b want 10", {busy, done}); end
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin @(posedge clock); #1; lat++; end
    tests_run++;
    if ({result_hi, result_lo, lat} !== {32'd10, 32'd30, 32'd33}) begin
      tests_failed++; $display("FAIL b2b_second got %h lat %0d want 0000000a0000001e lat 33", {result_hi, result_lo}, lat);
    end
  endtask

  task automatic test_mul_step4;
    int lat; logic [31:0] lo, hi; logic dz;
    issue(1'b1, 2'd0, 32'h1234_5678, 32'h9ABC_DEF0, lat, lo, hi, dz);
    tests_run++;
    if ({hi, lo, lat} !== {64'h0B00_EA4E_242D_2080, 32'd9}) begin
      tests_failed++; $display("FAIL step4_umul got %h lat %0d want 0b00ea4e242d2080 lat 9", {hi, lo}, lat);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clock);
    start = 1'b1; op = 2'd0; operand_a = 32'hDEAD_BEEF; operand_b = 32'h1234;
    @(posedge clock); #1; start = 1'b0;
    repeat (5) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if ({busy, done, div_by_zero, result_hi, result_lo} !== 67'd0) begin
      tests_failed++; $display("FAIL reset_mid got %b %h want 000 0", {busy, done, div_by_zero}, {result_hi, result_lo});
    end
    tests_run++;
    if ({busy4, dbz4, hi4, lo4} !== 66'd0) begin
      tests_failed++; $display("FAIL reset_mid4 got %b %h want 00 0", {busy4, dbz4}, {hi4, lo4});
    end
    @(negedge clock); reset = 1'b1;
    repeat (40) @(posedge clock);
    #1;
    tests_run++;
    if ({busy, done} !== 2'b00) begin tests_failed++; $display("FAIL reset_no_done got %b want 00", {busy, done}); end
  endtask

  initial begin
    test_reset();
    test_mul_directed();
    test_signed_and_dbz();
    test_random();
    test_flush();
    test_back_to_back();
    test_mul_step4();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
